// File: rtl/dmem_arbiter_pkg.sv
// Shared codes for the data-memory arbiter: RAM size codes, FSM encodings.
// Misalignment checking is enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
package dmem_arbiter_pkg;

  localparam logic [1:0] DMEM_ARB_IDLE = 2'd0;
  localparam logic [1:0] DMEM_ARB_OWN0 = 2'd1;
  localparam logic [1:0] DMEM_ARB_OWN1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = DMEM_ARB_IDLE,
    OWN0 = DMEM_ARB_OWN0,
    OWN1 = DMEM_ARB_OWN1
  } arb_state_e;

  localparam logic [1:0] WR_SB = 2'b00;
  localparam logic [1:0] WR_SH = 2'b01;
  localparam logic [1:0] WR_SW = 2'b10;

  localparam logic [2:0] RD_LB   = 3'b000;
  localparam logic [2:0] RD_LH   = 3'b001;
  localparam logic [2:0] RD_LW   = 3'b010;
  localparam logic [2:0] RD_LBU  = 3'b100;
  localparam logic [2:0] RD_LHU  = 3'b101;
  localparam logic [2:0] RD_NONE = 3'b111;

  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    return (c == 4'hf) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational misalignment detect for one RAM access.
// Only instantiated when DMEM_ARB_ALIGN_CHECK_EN is defined.
module dmem_align_chk
  import dmem_arbiter_pkg::*;
(
  input  logic       we,
  input  logic [1:0] wr_ctrl,
  input  logic [2:0] rd_ctrl,
  input  logic [1:0] addr,
  output logic       mis
);

  logic half;
  logic word;

  always_comb begin
    half = 1'b0;
    word = 1'b0;
    if (we) begin
      half = (wr_ctrl == WR_SH);
      word = (wr_ctrl == WR_SW);
    end else begin
      half = (rd_ctrl == RD_LH) || (rd_ctrl == RD_LHU);
      word = (rd_ctrl == RD_LW);
    end
    mis = (half && addr[0]) || (word && (addr != 2'b00));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the byte-addressed data RAM.
// Define DMEM_ARB_ALIGN_CHECK_EN to add m0_err/m1_err misalignment pulses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_wr_ctrl,
  input  logic [2:0]  m0_rd_ctrl,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_wr_ctrl,
  input  logic [2:0]  m1_rd_ctrl,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  output logic        m0_err,
  output logic        m1_err,
`endif
  output logic        ram_wr_en,
  output logic [1:0]  ram_wr_ctrl,
  output logic [2:0]  ram_rd_ctrl,
  output logic [31:0] ram_wr_addr,
  output logic [31:0] ram_rd_addr,
  output logic [31:0] ram_wr_data,
  input  logic [31:0] ram_rd_data
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  arb_state_e state, nstate;
  logic       last, nlast;
  logic [3:0] cnt, ncnt;
  logic       own1, o_req, x_req;
  logic       take, win, keep;
  logic       g0, g1, any;
  logic       s_req, s_we;
  logic [1:0] s_wr;
  logic [2:0] s_rd;
  logic [31:0] s_addr, s_wdata;
  logic       mis;

  assign own1  = (state == OWN1);
  assign o_req = own1 ? m1_req : m0_req;
  assign x_req = own1 ? m0_req : m1_req;

  always_comb begin
    take   = 1'b0;
    win    = 1'b0;
    keep   = 1'b0;
    nstate = state;
    nlast  = last;
    ncnt   = cnt;
    unique case (state)
      IDLE: begin
        take = m0_req | m1_req;
        win  = (m0_req & m1_req) ? ~last : m1_req;
      end
      default: begin
        if (o_req && (!x_req || cnt < MAXB)) begin
          take = 1'b1;
          win  = own1;
          keep = 1'b1;
        end else if (x_req) begin
          take = 1'b1;
          win  = ~own1;
        end
      end
    endcase
    if (take) begin
      nlast  = win;
      nstate = win ? OWN1 : OWN0;
      ncnt   = keep ? cnt_inc(cnt) : 4'd1;
    end else begin
      nstate = IDLE;
      ncnt   = 4'd0;
    end
  end

  assign g0 = take & ~win;
  assign g1 = take & win;

  // Outputs are forced low while reset is held, even with requests pending.
  assign any    = take & rst_n;
  assign m0_gnt = g0 & rst_n;
  assign m1_gnt = g1 & rst_n;

  assign s_req   = win ? m1_req     : m0_req;
  assign s_we    = win ? m1_we      : m0_we;
  assign s_wr    = win ? m1_wr_ctrl : m0_wr_ctrl;
  assign s_rd    = win ? m1_rd_ctrl : m0_rd_ctrl;
  assign s_addr  = win ? m1_addr    : m0_addr;
  assign s_wdata = win ? m1_wdata   : m0_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  dmem_align_chk u_align (
    .we      (s_we),
    .wr_ctrl (s_wr),
    .rd_ctrl (s_rd),
    .addr    (s_addr[1:0]),
    .mis     (mis)
  );
`else
  assign mis = 1'b0;
`endif

  assign ram_wr_en   = any & s_req & s_we & ~mis;
  assign ram_wr_ctrl = any ? s_wr : 2'b00;
  assign ram_rd_ctrl = !any ? 3'b000 : (s_we ? RD_NONE : s_rd);
  assign ram_wr_addr = any ? s_addr : 32'h0;
  assign ram_rd_addr = any ? s_addr : 32'h0;
  assign ram_wr_data = any ? s_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= 4'd0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
    end else begin
      state     <= nstate;
      last      <= nlast;
      cnt       <= ncnt;
      m0_rvalid <= g0 & ~m0_we;
      m1_rvalid <= g1 & ~m1_we;
      if (g0 && !m0_we)
        m0_rdata <= mis ? 32'h0 : ram_rd_data;
      if (g1 && !m1_we)
        m1_rdata <= mis ? 32'h0 : ram_rd_data;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      m0_err <= g0 & mis;
      m1_err <= g1 & mis;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian byte RAM model.
// Misalignment checks are exercised when DMEM_ARB_ALIGN_CHECK_EN is defined.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [1:0]  m0_wr_ctrl = 0, m1_wr_ctrl = 0;
  logic [2:0]  m0_rd_ctrl = 0, m1_rd_ctrl = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic        m0_err, m1_err;
`endif
  logic        ram_wr_en;
  logic [1:0]  ram_wr_ctrl;
  logic [2:0]  ram_rd_ctrl;
  logic [31:0] ram_wr_addr, ram_rd_addr, ram_wr_data, ram_rd_data;

  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h0;
  logic [31:0] pre_data = 32'h0;
  logic [7:0]  mem [0:255];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wr_ctrl(m0_wr_ctrl),
    .m0_rd_ctrl(m0_rd_ctrl), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wr_ctrl(m1_wr_ctrl),
    .m1_rd_ctrl(m1_rd_ctrl), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    .m0_err(m0_err), .m1_err(m1_err),
`endif
    .ram_wr_en(ram_wr_en), .ram_wr_ctrl(ram_wr_ctrl),
    .ram_rd_ctrl(ram_rd_ctrl), .ram_wr_addr(ram_wr_addr),
    .ram_rd_addr(ram_rd_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  function automatic logic [31:0] rd_model(input logic [7:0] a,
                                           input logic [2:0] c);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = mem[a];
    h = {mem[a + 8'd1], mem[a]};
    w = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    case (c)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  always_comb ram_rd_data = rd_model(ram_rd_addr[7:0], ram_rd_ctrl);

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 4; i++)
        mem[pre_addr + 8'(i)] <= pre_data[8*i +: 8];
    end else if (ram_wr_en) begin
      mem[ram_wr_addr[7:0]] <= ram_wr_data[7:0];
      if (ram_wr_ctrl != 2'b00)
        mem[ram_wr_addr[7:0] + 8'd1] <= ram_wr_data[15:8];
      if (ram_wr_ctrl == 2'b10) begin
        mem[ram_wr_addr[7:0] + 8'd2] <= ram_wr_data[23:16];
        mem[ram_wr_addr[7:0] + 8'd3] <= ram_wr_data[31:24];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    m0_req = 0;
    m1_req = 0;
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    m0_req = 1; m0_we = 0; m0_rd_ctrl = RD_LW; m0_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0)
      $display("FAIL reset_gnt got %b%b want 00", m0_gnt, m1_gnt);
    else passes++;
    checks++;
    if ({ram_wr_en, ram_rd_addr, ram_rd_ctrl} !== 36'h0)
      $display("FAIL reset_ram got en=%b addr=%h rc=%h want 0",
               ram_wr_en, ram_rd_addr, ram_rd_ctrl);
    else passes++;
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 66'h0)
      $display("FAIL reset_rsp got %b %b %h %h want 0",
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    else passes++;
    m0_req = 0;
    cyc();
    rst_n = 1;
    pre_we = 1; pre_addr = 8'h10; pre_data = 32'h11223344;
    cyc();
    pre_we = 0;
    @(negedge clk);
    checks++;
    if ({ram_wr_en, ram_wr_ctrl, ram_wr_addr, ram_wr_data} !== 67'h0)
      $display("FAIL idle_ram got en=%b addr=%h data=%h want 0",
               ram_wr_en, ram_wr_addr, ram_wr_data);
    else passes++;
    cyc();
  endtask

  task automatic test_load();
    m0_req = 1; m0_we = 0; m0_rd_ctrl = RD_LW; m0_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || ram_rd_addr !== 32'h10)
      $display("FAIL load_gnt got %b%b addr=%h want 10 addr=10",
               m0_gnt, m1_gnt, ram_rd_addr);
    else passes++;
    cyc();
    m0_req = 0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h11223344)
      $display("FAIL load_rsp got v=%b d=%h want 1 11223344",
               m0_rvalid, m0_rdata);
    else passes++;
    checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 || m1_gnt !== 1'b0)
      $display("FAIL load_m1_quiet got %b %h %b want 0 0 0",
               m1_rvalid, m1_rdata, m1_gnt);
    else passes++;
    cyc();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h11223344)
      $display("FAIL load_hold got v=%b d=%h want 0 11223344",
               m0_rvalid, m0_rdata);
    else passes++;
    cyc();
  endtask

  task automatic test_tie();
    reset_pulse();
    m0_req = 1; m0_we = 0; m0_rd_ctrl = RD_LW; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_rd_ctrl = RD_LW; m1_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10)
      $display("FAIL tie_first got %b%b want 10", m0_gnt, m1_gnt);
    else passes++;
    cyc();
    m0_req = 0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01)
      $display("FAIL tie_handoff got %b%b want 01", m0_gnt, m1_gnt);
    else passes++;
    cyc();
    m1_req = 0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h11223344)
      $display("FAIL tie_m1_rsp got %b %h want 1 11223344",
               m1_rvalid, m1_rdata);
    else passes++;
    cyc();
    m0_req = 1;
    cyc();
    m0_req = 0;
    cyc();
    m0_req = 1;
    m1_req = 1;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01)
      $display("FAIL tie_after_m0 got %b%b want 01", m0_gnt, m1_gnt);
    else passes++;
    cyc();
    m0_req = 0;
    m1_req = 0;
    cyc();
  endtask

  task automatic test_burst();
    logic [7:0] exp0;
    exp0 = 8'b1100_1111;
    reset_pulse();
    m0_req = 1; m0_we = 0; m0_rd_ctrl = RD_LW; m0_addr = 32'h10;
    m1_we = 0; m1_rd_ctrl = RD_LW; m1_addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      m1_req = (c != 6);
      @(negedge clk);
      checks++;
      if (m0_gnt !== exp0[c] || m1_gnt !== ~exp0[c])
        $display("FAIL burst_c%0d got %b%b want %b%b",
                 c, m0_gnt, m1_gnt, exp0[c], ~exp0[c]);
      else passes++;
      if (c == 5 || c == 6) begin
        checks++;
        if (m1_rvalid !== 1'b1)
          $display("FAIL burst_rvalid_c%0d got %b want 1", c, m1_rvalid);
        else passes++;
      end
      cyc();
    end
    m0_req = 0;
    m1_req = 0;
    cyc();
    cyc();
  endtask

  task automatic test_store_load();
    m1_req = 1; m1_we = 1; m1_wr_ctrl = WR_SW;
    m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1 || ram_wr_en !== 1'b1 || ram_wr_addr !== 32'h20 ||
        ram_wr_data !== 32'hDEADBEEF)
      $display("FAIL sw_issue got g=%b en=%b a=%h d=%h want 1 1 20 deadbeef",
               m1_gnt, ram_wr_en, ram_wr_addr, ram_wr_data);
    else passes++;
    checks++;
    if (ram_rd_data !== 32'h0)
      $display("FAIL sw_rd_blocked got %h want 0", ram_rd_data);
    else passes++;
    cyc();
    m1_req = 0; m1_we = 0;
    m0_req = 1; m0_we = 0; m0_rd_ctrl = RD_LB; m0_addr = 32'h23;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b0)
      $display("FAIL lb_gnt got g=%b m1v=%b want 1 0", m0_gnt, m1_rvalid);
    else passes++;
    cyc();
    m0_rd_ctrl = RD_LHU; m0_addr = 32'h22;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hFFFFFFDE)
      $display("FAIL lb_data got %b %h want 1 ffffffde", m0_rvalid, m0_rdata);
    else passes++;
    cyc();
    m0_rd_ctrl = RD_LW; m0_addr = 32'h20;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000DEAD)
      $display("FAIL lhu_data got %b %h want 1 0000dead", m0_rvalid, m0_rdata);
    else passes++;
    cyc();
    m0_req = 0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF)
      $display("FAIL lw_data got %b %h want 1 deadbeef", m0_rvalid, m0_rdata);
    else passes++;
    cyc();
  endtask

  task automatic test_misalign();
    m0_req = 1; m0_we = 1; m0_wr_ctrl = WR_SH;
    m0_addr = 32'h21; m0_wdata = 32'h0000AAAA;
    @(negedge clk);
    checks++;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if (m0_gnt !== 1'b1 || ram_wr_en !== 1'b0)
      $display("FAIL sh_mis_issue got g=%b en=%b want 1 0", m0_gnt, ram_wr_en);
    else passes++;
`else
    if (m0_gnt !== 1'b1 || ram_wr_en !== 1'b1)
      $display("FAIL sh_mis_issue got g=%b en=%b want 1 1", m0_gnt, ram_wr_en);
    else passes++;
`endif
    cyc();
    m0_req = 0; m0_we = 0;
    @(negedge clk);
    checks++;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if (m0_err !== 1'b1 || mem[8'h20] !== 8'hEF || mem[8'h21] !== 8'hBE)
      $display("FAIL sh_mis_err got err=%b m20=%h m21=%h want 1 ef be",
               m0_err, mem[8'h20], mem[8'h21]);
    else passes++;
`else
    if (mem[8'h21] !== 8'hAA || mem[8'h22] !== 8'hAA || mem[8'h20] !== 8'hEF)
      $display("FAIL sh_mis_write got m20=%h m21=%h m22=%h want ef aa aa",
               mem[8'h20], mem[8'h21], mem[8'h22]);
    else passes++;
`endif
    checks++;
    if (m0_rvalid !== 1'b0)
      $display("FAIL sh_no_rsp got %b want 0", m0_rvalid);
    else passes++;
    cyc();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    m0_req = 1; m0_we = 0; m0_rd_ctrl = RD_LW; m0_addr = 32'h22;
    cyc();
    m0_req = 0;
    @(negedge clk);
    checks++;
    if (m0_err !== 1'b1 || m0_rvalid !== 1'b1 || m0_rdata !== 32'h0)
      $display("FAIL lw_mis got err=%b v=%b d=%h want 1 1 0",
               m0_err, m0_rvalid, m0_rdata);
    else passes++;
    cyc();
`endif
  endtask

  task automatic test_reset_mid();
    m1_req = 1; m1_we = 0; m1_rd_ctrl = RD_LW; m1_addr = 32'h20;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1)
      $display("FAIL rstmid_gnt got %b want 1", m1_gnt);
    else passes++;
    cyc();
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || m1_gnt !== 1'b0 || m0_gnt !== 1'b0)
      $display("FAIL rstmid_drop got v=%b g=%b%b want 0 00",
               m1_rvalid, m0_gnt, m1_gnt);
    else passes++;
    checks++;
    if ({ram_wr_en, ram_rd_addr, ram_rd_ctrl, m0_rdata, m1_rdata} !== 100'h0)
      $display("FAIL rstmid_zero got en=%b a=%h rd0=%h rd1=%h want 0",
               ram_wr_en, ram_rd_addr, m0_rdata, m1_rdata);
    else passes++;
    cyc();
    m1_req = 0;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || ram_wr_en !== 1'b0)
      $display("FAIL rstmid_after got v=%b en=%b want 0 0",
               m1_rvalid, ram_wr_en);
    else passes++;
    cyc();
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_tie();
    test_burst();
    test_store_load();
    test_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
